// File: rtl/rope_constraint_sweeper.sv
// rope_constraint_sweeper
//
// Holds the rope node positions and runs ITER Gauss-Seidel sweeps of them
// through an external combinational constraint stage. For each node 1..N-1,
// in ascending order, FETCH registers the up/current/down operands. APPLY
// then writes the enforced position returned by the stage back into storage.
// Node 0 is the pinned anchor, and only the host can write it.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               begin ITER sweeps (sampled only in IDLE)
//   busy, done          busy in FETCH/APPLY; done is a one-cycle pulse in DONE
//   wr_en/wr_addr/wr_x/wr_y  host write (IDLE or DONE only, in-range addr only)
//   rd_addr, rd_x/rd_y  host read, registered, 0 for out-of-range addr
//   ec_up_*, ec_*, ec_down_*, ec_is_last  registered operands to the stage
//   ec_x_enf, ec_y_enf  enforced position from the stage (combinational)
//   dbg_state           current FSM state (IDLE=0, FETCH=1, APPLY=2, DONE=3)
//
// Handshake: there is no valid/ready pair. start is a level that the design
// samples on the rising edge only while it is in IDLE. busy covers the whole
// run, and done marks its completion for exactly one cycle.
module rope_constraint_sweeper #(
  parameter int N_NODES = 16,
  parameter int ADDR_W  = 4,
  parameter int ITER    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_x,
  input  logic [31:0]       wr_y,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_x,
  output logic [31:0]       rd_y,
  output logic [31:0]       ec_up_x,
  output logic [31:0]       ec_up_y,
  output logic [31:0]       ec_x,
  output logic [31:0]       ec_y,
  output logic [31:0]       ec_down_x,
  output logic [31:0]       ec_down_y,
  output logic              ec_is_last,
  input  logic [31:0]       ec_x_enf,
  input  logic [31:0]       ec_y_enf,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Array index width is sized to the storage, not to the host address bus,
  // so that a wider ADDR_W never produces out-of-range array indexing.
  localparam int IW = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam int SW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N_NODES - 1);
  localparam logic [SW-1:0]     LAST_SWEEP = SW'(ITER - 1);
  localparam logic [ADDR_W:0]   N_EXT      = (ADDR_W + 1)'(N_NODES);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] idx_q;
  logic [SW-1:0]     sweep_q;

  logic [31:0] node_x [N_NODES];
  logic [31:0] node_y [N_NODES];

  logic [IW-1:0] cur_i, up_i, down_i, wr_i, rd_i;
  logic          is_last, last_sweep, wr_ok, rd_ok;

  assign cur_i      = idx_q[IW-1:0];
  assign up_i       = cur_i - IW'(1);
  assign is_last    = (idx_q == LAST_IDX);
  // The last node has no lower neighbour, so it is presented as its own down.
  assign down_i     = is_last ? cur_i : cur_i + IW'(1);
  assign last_sweep = (sweep_q == LAST_SWEEP);

  assign wr_i  = wr_addr[IW-1:0];
  assign rd_i  = rd_addr[IW-1:0];
  assign wr_ok = wr_en && ((state_q == IDLE) || (state_q == DONE)) &&
                 ({1'b0, wr_addr} < N_EXT);
  assign rd_ok = ({1'b0, rd_addr} < N_EXT);

  assign busy      = (state_q == FETCH) || (state_q == APPLY);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = APPLY;
      APPLY:   state_d = (is_last && last_sweep) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, node storage, operand and read registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= ADDR_W'(1);
      sweep_q    <= '0;
      for (int i = 0; i < N_NODES; i++) begin
        node_x[i] <= '0;
        node_y[i] <= '0;
      end
      rd_x       <= '0;
      rd_y       <= '0;
      ec_up_x    <= '0;
      ec_up_y    <= '0;
      ec_x       <= '0;
      ec_y       <= '0;
      ec_down_x  <= '0;
      ec_down_y  <= '0;
      ec_is_last <= 1'b0;
    end else begin
      // The read sees storage before any write on this same edge.
      rd_x <= rd_ok ? node_x[rd_i] : '0;
      rd_y <= rd_ok ? node_y[rd_i] : '0;

      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q   <= ADDR_W'(1);
            sweep_q <= '0;
          end
        end
        FETCH: begin
          ec_up_x    <= node_x[up_i];
          ec_up_y    <= node_y[up_i];
          ec_x       <= node_x[cur_i];
          ec_y       <= node_y[cur_i];
          ec_down_x  <= node_x[down_i];
          ec_down_y  <= node_y[down_i];
          ec_is_last <= is_last;
        end
        APPLY: begin
          node_x[cur_i] <= ec_x_enf;
          node_y[cur_i] <= ec_y_enf;
          if (!is_last) begin
            idx_q <= idx_q + ADDR_W'(1);
          end else if (!last_sweep) begin
            sweep_q <= sweep_q + SW'(1);
            idx_q   <= ADDR_W'(1);
          end
        end
        default: ;
      endcase

      // Host writes are only accepted in IDLE/DONE. The sweep never writes
      // in those states, so both write sources are mutually exclusive.
      if (wr_ok) begin
        node_x[wr_i] <= wr_x;
        node_y[wr_i] <= wr_y;
      end
    end
  end

endmodule

// File: tb/tb_rope_constraint_sweeper.sv
// tb_rope_constraint_sweeper
//
// Directed bench for rope_constraint_sweeper (N_NODES=16, ADDR_W=5, ITER=4).
// The wider address bus makes out-of-range host addresses such as 20 usable.
// The constraint stage is a stub selected by stub_mode:
//   0: x = ec_up_x + 1, y = ec_y   (shows sweep order / up = fresh value)
//   1: x = ec_x + 1,    y = ec_y   (counts how many times each node is applied)
module tb_rope_constraint_sweeper;

  localparam int N      = 16;
  localparam int AW     = 5;
  localparam int IT     = 4;
  localparam int BUSY_N = 2 * (N - 1) * IT;  // 120

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          busy, done;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_x = '0, wr_y = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_x, rd_y;
  logic [31:0]   ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y;
  logic          ec_is_last;
  logic [31:0]   ec_x_enf, ec_y_enf;
  logic [1:0]    dbg_state;

  int stub_mode = 0;

  always_comb begin
    ec_x_enf = (stub_mode == 0) ? ec_up_x + 32'd1 : ec_x + 32'd1;
    ec_y_enf = ec_y;
  end

  rope_constraint_sweeper #(.N_NODES(N), .ADDR_W(AW), .ITER(IT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .rd_addr(rd_addr), .rd_x(rd_x), .rd_y(rd_y),
    .ec_up_x(ec_up_x), .ec_up_y(ec_up_y), .ec_x(ec_x), .ec_y(ec_y),
    .ec_down_x(ec_down_x), .ec_down_y(ec_down_y), .ec_is_last(ec_is_last),
    .ec_x_enf(ec_x_enf), .ec_y_enf(ec_y_enf), .dbg_state(dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] y_pat [N];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic write_node(input int a, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_x = x; wr_y = y;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_node(input int a, output logic [31:0] x, output logic [31:0] y);
    @(negedge clk);
    rd_addr = AW'(a);
    @(negedge clk);
    x = rd_x; y = rd_y;
  endtask

  // Compare nodes 0..N-1 against exp_q (x values), with y expected = y_pat.
  task automatic check_nodes(input string tag);
    logic [31:0] x, y;
    for (int i = 0; i < N; i++) begin
      read_node(i, x, y);
      check($sformatf("%s_x%0d", tag, i), x, exp_q.pop_front());
      check($sformatf("%s_y%0d", tag, i), y, y_pat[i]);
    end
  endtask

  // Runs one start and watches a fixed window of 140 cycles.
  // inject: 0 none, 1 write+start while busy and start in DONE,
  //         2 reset in the 5th busy cycle, 3 write alongside start.
  // seq_err counts operand-sequence errors seen in APPLY cycles.
  task automatic run_sweep(input int inject, output int busy_n, output int done_n,
                           output int seq_err);
    int k;
    int idx;
    k = 0; busy_n = 0; done_n = 0; seq_err = 0;
    @(negedge clk);
    start = 1'b1;
    if (inject == 3) begin
      wr_en = 1'b1; wr_addr = AW'(1); wr_x = 32'h0001_0000; wr_y = y_pat[1];
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < BUSY_N + 20; c++) begin
      if (busy === 1'b1) begin
        if (k % 2 == 1) begin
          idx = (k / 2) % (N - 1) + 1;
          if (ec_is_last !== (idx == N - 1)) seq_err++;
          if (ec_y !== y_pat[idx]) seq_err++;
          if (ec_up_y !== y_pat[idx - 1]) seq_err++;
          if (stub_mode == 0 && ec_up_x !== 32'h10 + 32'(idx - 1)) seq_err++;
          if (idx == N - 1) begin
            if (ec_down_x !== ec_x || ec_down_y !== ec_y) seq_err++;
          end else if (ec_down_y !== y_pat[idx + 1]) seq_err++;
        end
        if (inject == 1 && k == 10) begin
          wr_en = 1'b1; wr_addr = AW'(3); wr_x = 32'hdead_beef; wr_y = 32'h0;
          start = 1'b1;
        end
        if (inject == 2 && k == 4) rst = 1'b1;
        k++;
        busy_n++;
      end
      if (done === 1'b1) begin
        done_n++;
        if (inject == 1) start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0; rst = 1'b0;
    end
  endtask

  initial begin : main
    int bn, dn, se;
    logic [31:0] x, y;

    for (int i = 0; i < N; i++) y_pat[i] = 32'h5a00_0000 | 32'(i << 8) | 32'(i);

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_ec_x", ec_x, 32'd0);
    check("rst_ec_up_y", ec_up_y, 32'd0);
    check("rst_ec_down_x", ec_down_x, 32'd0);
    check("rst_ec_is_last", 32'(ec_is_last), 32'd0);
    read_node(5, x, y);
    check("rst_rd_x5", x, 32'd0);
    check("rst_rd_y5", y, 32'd0);

    // ordering: x = up + 1, node0.x = 0x10, others 0
    stub_mode = 0;
    for (int i = 0; i < N; i++) write_node(i, (i == 0) ? 32'h10 : 32'h0, y_pat[i]);
    run_sweep(0, bn, dn, se);
    check("ord_busy_cycles", 32'(bn), 32'd120);
    check("ord_done_pulses", 32'(dn), 32'd1);
    check("ord_seq_err", 32'(se), 32'd0);
    for (int i = 0; i < N; i++) exp_q.push_back(32'h10 + 32'(i));
    check_nodes("ord");

    // iteration count: x = cur + 1, four sweeps add 4
    stub_mode = 1;
    for (int i = 0; i < N; i++) write_node(i, 32'h000c_9b36, y_pat[i]);
    run_sweep(0, bn, dn, se);
    check("itr_busy_cycles", 32'(bn), 32'd120);
    check("itr_done_pulses", 32'(dn), 32'd1);
    check("itr_seq_err", 32'(se), 32'd0);
    exp_q.push_back(32'h000c_9b36);
    for (int i = 1; i < N; i++) exp_q.push_back(32'h000c_9b3a);
    check_nodes("itr");

    // write and start while busy dropped, start in DONE ignored
    run_sweep(1, bn, dn, se);
    check("gate_busy_cycles", 32'(bn), 32'd120);
    check("gate_done_pulses", 32'(dn), 32'd1);
    check("gate_seq_err", 32'(se), 32'd0);
    check("gate_idle_after", 32'(busy), 32'd0);
    read_node(3, x, y);
    check("gate_node3_x", x, 32'h000c_9b3e);

    // out-of-range host write and read
    write_node(20, 32'hdead_beef, 32'hcafe_f00d);
    read_node(4, x, y);
    check("oor_node4_x", x, 32'h000c_9b3e);
    check("oor_node4_y", y, y_pat[4]);
    read_node(0, x, y);
    check("oor_node0_x", x, 32'h000c_9b36);
    read_node(20, x, y);
    check("oor_rd20_x", x, 32'd0);
    check("oor_rd20_y", y, 32'd0);

    // write in the same IDLE cycle as start is used by the sweep
    run_sweep(3, bn, dn, se);
    check("sw_done_pulses", 32'(dn), 32'd1);
    check("sw_seq_err", 32'(se), 32'd0);
    read_node(1, x, y);
    check("sw_node1_x", x, 32'h0001_0004);
    read_node(2, x, y);
    check("sw_node2_x", x, 32'h000c_9b42);

    // reset in the 5th busy cycle
    run_sweep(2, bn, dn, se);
    check("mid_rst_busy_cycles", 32'(bn), 32'd5);
    check("mid_rst_done_pulses", 32'(dn), 32'd0);
    check("mid_rst_seq_err", 32'(se), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_ec_up_x", ec_up_x, 32'd0);
    check("mid_rst_ec_x", ec_x, 32'd0);
    check("mid_rst_ec_y", ec_y, 32'd0);
    check("mid_rst_ec_down_y", ec_down_y, 32'd0);
    check("mid_rst_ec_is_last", 32'(ec_is_last), 32'd0);
    for (int i = 0; i < N; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < N; i++) y_pat[i] = 32'd0;
    check_nodes("mid_rst");

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
